// File: rtl/psum_accum_buf.sv
// Partial-sum accumulation buffer around an external fixed-latency SIMD lane adder.
// Group 0 seeds the buffer with add_b=0; the final group streams sums downstream instead of writing back.
module psum_accum_buf #(
  parameter int LANES   = 8,
  parameter int LANE_W  = 16,
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int ADD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AW:0]             cfg_pix_num,
  input  logic [7:0]              cfg_grp_num,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [LANES*LANE_W-1:0] psum_data,
  output logic [LANES*LANE_W-1:0] add_a,
  output logic [LANES*LANE_W-1:0] add_b,
  input  logic [LANES*LANE_W-1:0] add_s,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [LANES*LANE_W-1:0] out_data
);

  localparam int DW = LANES * LANE_W;
  localparam logic [AW:0] MIN_PIX = (AW+1)'(ADD_LAT + 2);
  localparam logic [AW:0] MAX_PIX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW:0]     r_pix_num;
  logic [7:0]      r_grp_num;
  logic [AW-1:0]   r_pix_cnt;
  logic [7:0]      r_grp_cnt;
  logic            r_cfg_err;

  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_rd_data;
  logic [DW-1:0]   r_add_a;
  logic            r_b_zero;

  logic [ADD_LAT:0]         r_tag_vld;
  logic [ADD_LAT:0][AW-1:0] r_tag_pix;
  logic [ADD_LAT:0]         r_tag_out;
  logic [ADD_LAT:0]         r_tag_last;

  logic w_cfg_ok;
  logic w_start_ok;
  logic w_beat;
  logic w_pix_end;
  logic w_grp_end;
  logic w_last_beat;
  logic w_emit;
  logic w_wr_en;

  assign w_cfg_ok    = (cfg_pix_num >= MIN_PIX) && (cfg_pix_num <= MAX_PIX) && (cfg_grp_num != 8'd0);
  assign w_start_ok  = start && (r_state == S_IDLE) && w_cfg_ok;
  assign w_beat      = psum_valid && psum_ready;
  assign w_pix_end   = ({1'b0, r_pix_cnt} == (r_pix_num - (AW+1)'(1)));
  assign w_grp_end   = (r_grp_cnt == (r_grp_num - 8'd1));
  assign w_last_beat = w_beat && w_pix_end && w_grp_end;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_ACCUM;
      S_ACCUM: if (w_last_beat) w_next = S_DRAIN;
      S_DRAIN: if (r_tag_vld[ADD_LAT-1:0] == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    psum_ready = (r_state == S_ACCUM);
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    cfg_err    = r_cfg_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_num <= '0;
      r_grp_num <= '0;
      r_pix_cnt <= '0;
      r_grp_cnt <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= start && (r_state == S_IDLE) && !w_cfg_ok;
      if (w_start_ok) begin
        r_pix_num <= cfg_pix_num;
        r_grp_num <= cfg_grp_num;
        r_pix_cnt <= '0;
        r_grp_cnt <= '0;
      end else if (w_beat) begin
        if (w_pix_end) begin
          r_pix_cnt <= '0;
          r_grp_cnt <= r_grp_cnt + 8'd1;
        end else begin
          r_pix_cnt <= r_pix_cnt + AW'(1);
        end
      end
    end
  end

  // Tag pipeline mirrors the read + adder path so writeback/emit line up with add_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a    <= '0;
      r_b_zero   <= 1'b1;
      r_tag_vld  <= '0;
      r_tag_pix  <= '0;
      r_tag_out  <= '0;
      r_tag_last <= '0;
    end else begin
      if (w_beat) begin
        r_add_a  <= psum_data;
        r_b_zero <= (r_grp_cnt == 8'd0);
      end
      r_tag_vld  <= {r_tag_vld[ADD_LAT-1:0], w_beat};
      r_tag_pix  <= {r_tag_pix[ADD_LAT-1:0], r_pix_cnt};
      r_tag_out  <= {r_tag_out[ADD_LAT-1:0], w_grp_end};
      r_tag_last <= {r_tag_last[ADD_LAT-1:0], w_grp_end && w_pix_end};
    end
  end

  // NOTE: the buffer RAM is deliberately not reset; group 0 forces add_b=0 so stale contents never matter.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_tag_pix[ADD_LAT]] <= add_s;
    if (w_beat)  r_rd_data <= r_mem[r_pix_cnt];
  end

  assign w_emit  = r_tag_vld[ADD_LAT] && r_tag_out[ADD_LAT];
  assign w_wr_en = r_tag_vld[ADD_LAT] && !r_tag_out[ADD_LAT] && !rst;

  assign add_a     = r_add_a;
  assign add_b     = r_b_zero ? '0 : r_rd_data;
  assign out_valid = w_emit;
  assign out_last  = w_emit && r_tag_last[ADD_LAT];
  assign out_data  = w_emit ? add_s : '0;

endmodule

// File: tb/tb_psum_accum_buf.sv
// Directed bench for psum_accum_buf with a 2-cycle lane-adder model closing the loop.
module tb_psum_accum_buf;

  localparam int LANES = 8;
  localparam int LW    = 16;
  localparam int DW    = LANES * LW;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW:0]   cfg_pix_num = '0;
  logic [7:0]    cfg_grp_num = '0;
  logic          start = 1'b0;
  logic          busy, done, cfg_err;
  logic          psum_valid = 1'b0;
  logic          psum_ready;
  logic [DW-1:0] psum_data = '0;
  logic [DW-1:0] add_a, add_b, add_s;
  logic          out_valid, out_last;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  psum_accum_buf dut (
    .clk(clk), .rst(rst), .cfg_pix_num(cfg_pix_num), .cfg_grp_num(cfg_grp_num),
    .start(start), .busy(busy), .done(done), .cfg_err(cfg_err),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LW +: LW] = a[i*LW +: LW] + b[i*LW +: LW];
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp(input logic [15:0] base, input logic [15:0] step);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LW +: LW] = base + 16'(i) * step;
    return r;
  endfunction

  // External adder: operands at cycle T+1 -> sum at T+3
  logic [DW-1:0] sp1 = '0;
  logic [DW-1:0] sp2 = '0;
  always @(posedge clk) begin
    sp1 <= lane_add(add_a, add_b);
    sp2 <= sp1;
    cyc <= cyc + 1;
  end
  assign add_s = sp2;

  int            acc_q[$];
  int            oc_q[$];
  logic [DW-1:0] od_q[$];
  logic          ol_q[$];
  int            done_q[$];
  logic [DW-1:0] vec_q[$];

  always @(negedge clk) begin
    if (psum_valid && psum_ready) acc_q.push_back(cyc);
    if (out_valid) begin
      oc_q.push_back(cyc);
      od_q.push_back(out_data);
      ol_q.push_back(out_last);
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic clear_mon();
    acc_q.delete(); oc_q.delete(); od_q.delete(); ol_q.delete(); done_q.delete();
  endtask

  // Drives one tile from vec_q; optional gaps, ignored mid-tile start, or reset abort.
  task automatic run_tile(input int pix, input int grp, input bit gaps,
                          input int mid_start, input int abort_at, output bit ok);
    bit acc;
    ok = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    cfg_pix_num = (AW+1)'(pix); cfg_grp_num = 8'(grp); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < pix * grp; b++) begin
      if (b == abort_at) begin
        rst = 1'b1; psum_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      psum_valid = 1'b1;
      psum_data  = vec_q[b];
      if (b == mid_start) begin
        start = 1'b1; cfg_pix_num = 9'd8; cfg_grp_num = 8'd1;
      end
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        @(negedge clk);
        acc = psum_ready;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!acc) begin
        psum_valid = 1'b0;
        return;
      end
      if (gaps) begin
        psum_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    psum_valid = 1'b0;
    for (int w = 0; w < 40 && done_q.size() == 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    ok = (done_q.size() != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, cfg_err, psum_ready, out_valid, out_last} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, cfg_err, psum_ready, out_valid, out_last});
    end
    n_cmp++;
    if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++;
    if (add_a !== '0) begin n_err++; $display("FAIL reset_add_a: got %h want 0", add_a); end
    n_cmp++;
    if (add_b !== '0) begin n_err++; $display("FAIL reset_add_b: got %h want 0", add_b); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // pix=4 grp=1: every beat goes straight out, latency 3, done the cycle after the last output.
  task automatic test_single_group();
    bit ok;
    logic [DW-1:0] exp_v;
    exp_v = ramp(16'd1, 16'd1);
    vec_q.delete();
    for (int b = 0; b < 4; b++) vec_q.push_back(exp_v);
    run_tile(4, 1, 1'b0, -1, -1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t1_done_timeout: got no done want done pulse"); end
    n_cmp++;
    if (oc_q.size() != 4) begin n_err++; $display("FAIL t1_out_count: got %0d want 4", oc_q.size()); end
    for (int i = 0; i < oc_q.size() && i < 4; i++) begin
      n_cmp++;
      if (od_q[i] !== exp_v) begin n_err++; $display("FAIL t1_data[%0d]: got %h want %h", i, od_q[i], exp_v); end
      n_cmp++;
      if (ol_q[i] !== (i == 3)) begin n_err++; $display("FAIL t1_last[%0d]: got %b want %b", i, ol_q[i], i == 3); end
      if (i < acc_q.size()) begin
        n_cmp++;
        if (oc_q[i] - acc_q[i] != 3) begin n_err++; $display("FAIL t1_latency[%0d]: got %0d want 3", i, oc_q[i] - acc_q[i]); end
      end
    end
    if (oc_q.size() == 4 && done_q.size() > 0) begin
      n_cmp++;
      if (done_q[0] != oc_q[3] + 1) begin n_err++; $display("FAIL t1_done_cycle: got %0d want %0d", done_q[0], oc_q[3] + 1); end
    end
    n_cmp++;
    if (done_q.size() != 1) begin n_err++; $display("FAIL t1_done_count: got %0d want 1", done_q.size()); end
  endtask

  // pix=4 grp=3, all lanes 0x0010: 4 outputs of 0x0030, emitted only for group 2.
  task automatic test_multi_group();
    bit ok;
    logic [DW-1:0] exp_v;
    exp_v = ramp(16'h0030, 16'd0);
    vec_q.delete();
    for (int b = 0; b < 12; b++) vec_q.push_back(ramp(16'h0010, 16'd0));
    run_tile(4, 3, 1'b0, -1, -1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t2_done_timeout: got no done want done pulse"); end
    n_cmp++;
    if (oc_q.size() != 4) begin n_err++; $display("FAIL t2_out_count: got %0d want 4", oc_q.size()); end
    for (int i = 0; i < oc_q.size() && i < 4; i++) begin
      n_cmp++;
      if (od_q[i] !== exp_v) begin n_err++; $display("FAIL t2_data[%0d]: got %h want %h", i, od_q[i], exp_v); end
      if (8 + i < acc_q.size()) begin
        n_cmp++;
        if (oc_q[i] != acc_q[8 + i] + 3) begin n_err++; $display("FAIL t2_out_cycle[%0d]: got %0d want %0d", i, oc_q[i], acc_q[8 + i] + 3); end
      end
    end
  endtask

  // pix=4 grp=2: lane 0 0xFFFF+0x0002 wraps to 0x0001; other lanes 5+7=12.
  task automatic test_wrap();
    bit ok;
    logic [DW-1:0] g0, g1, exp_v;
    g0 = ramp(16'h0005, 16'd0); g0[15:0] = 16'hFFFF;
    g1 = ramp(16'h0007, 16'd0); g1[15:0] = 16'h0002;
    exp_v = ramp(16'h000C, 16'd0); exp_v[15:0] = 16'h0001;
    vec_q.delete();
    for (int b = 0; b < 4; b++) vec_q.push_back(g0);
    for (int b = 0; b < 4; b++) vec_q.push_back(g1);
    run_tile(4, 2, 1'b0, -1, -1, ok);
    n_cmp++;
    if (oc_q.size() != 4 || !ok) begin n_err++; $display("FAIL t3_out_count: got %0d want 4", oc_q.size()); end
    for (int i = 0; i < oc_q.size() && i < 4; i++) begin
      n_cmp++;
      if (od_q[i] !== exp_v) begin n_err++; $display("FAIL t3_data[%0d]: got %h want %h", i, od_q[i], exp_v); end
    end
  endtask

  // pix=5 grp=2 with a bubble after every beat; per-pixel sums 0x100*p + 0x10 + 2*lane.
  task automatic test_bubbles();
    bit ok;
    logic [DW-1:0] exp_v;
    vec_q.delete();
    for (int p = 0; p < 5; p++) vec_q.push_back(ramp(16'(p * 256), 16'd1));
    for (int p = 0; p < 5; p++) vec_q.push_back(ramp(16'h0010, 16'd1));
    run_tile(5, 2, 1'b1, -1, -1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL t4_done_timeout: got no done want done pulse"); end
    n_cmp++;
    if (oc_q.size() != 5) begin n_err++; $display("FAIL t4_out_count: got %0d want 5", oc_q.size()); end
    for (int i = 0; i < oc_q.size() && i < 5; i++) begin
      exp_v = ramp(16'(i * 256 + 16), 16'd2);
      n_cmp++;
      if (od_q[i] !== exp_v) begin n_err++; $display("FAIL t4_data[%0d]: got %h want %h", i, od_q[i], exp_v); end
      n_cmp++;
      if (ol_q[i] !== (i == 4)) begin n_err++; $display("FAIL t4_last[%0d]: got %b want %b", i, ol_q[i], i == 4); end
    end
  endtask

  // Largest tile: address counter reaches DEPTH-1; sums p + 1 per lane.
  task automatic test_max_depth();
    bit ok;
    int bad;
    vec_q.delete();
    for (int p = 0; p < 256; p++) vec_q.push_back(ramp(16'(p), 16'd0));
    for (int p = 0; p < 256; p++) vec_q.push_back(ramp(16'd1, 16'd0));
    run_tile(256, 2, 1'b0, -1, -1, ok);
    n_cmp++;
    if (oc_q.size() != 256 || !ok) begin n_err++; $display("FAIL tmax_out_count: got %0d want 256", oc_q.size()); end
    bad = 0;
    for (int i = 0; i < oc_q.size() && i < 256; i++)
      if (od_q[i] !== ramp(16'(i + 1), 16'd0) || ol_q[i] !== (i == 255)) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL tmax_data: got %0d bad beats want 0", bad); end
  endtask

  // Rejected configurations pulse cfg_err; a start during a tile is ignored.
  task automatic test_cfg_err();
    bit ok;
    int pix_tab[3] = '{3, 257, 4};
    int grp_tab[3] = '{1, 1, 0};
    logic [DW-1:0] exp_v;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      cfg_pix_num = (AW+1)'(pix_tab[k]); cfg_grp_num = 8'(grp_tab[k]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({cfg_err, busy, psum_ready} !== 3'b100) begin
        n_err++; $display("FAIL t5_reject[%0d]: got err/busy/rdy %b want 100", k, {cfg_err, busy, psum_ready});
      end
      @(negedge clk);
      n_cmp++;
      if ({cfg_err, busy} !== 2'b00) begin n_err++; $display("FAIL t5_pulse[%0d]: got err/busy %b want 00", k, {cfg_err, busy}); end
    end
    exp_v = ramp(16'h0A00, 16'd1);
    vec_q.delete();
    for (int b = 0; b < 4; b++) vec_q.push_back(exp_v);
    run_tile(4, 1, 1'b0, 1, -1, ok);
    n_cmp++;
    if (oc_q.size() != 4 || acc_q.size() != 4 || !ok) begin
      n_err++; $display("FAIL t5_busy_start: got %0d outs %0d beats want 4 4", oc_q.size(), acc_q.size());
    end
    for (int i = 0; i < oc_q.size() && i < 4; i++) begin
      n_cmp++;
      if (od_q[i] !== exp_v) begin n_err++; $display("FAIL t5_data[%0d]: got %h want %h", i, od_q[i], exp_v); end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL t5_idle: got busy %b want 0", busy); end
  endtask

  // Reset in group 1 drops in-flight beats; the next tile is clean without a buffer clear.
  task automatic test_rst_mid();
    bit ok;
    logic [DW-1:0] exp_v;
    vec_q.delete();
    for (int b = 0; b < 8; b++) vec_q.push_back(ramp(16'h1111, 16'd0));
    run_tile(4, 2, 1'b0, -1, 5, ok);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, cfg_err, psum_ready, out_valid, out_last} !== 6'b0) begin
      n_err++; $display("FAIL t6_ctrl: got %b want 000000", {busy, done, cfg_err, psum_ready, out_valid, out_last});
    end
    n_cmp++;
    if (add_a !== '0 || add_b !== '0 || out_data !== '0) begin
      n_err++; $display("FAIL t6_data_zero: got a=%h b=%h o=%h want 0", add_a, add_b, out_data);
    end
    clear_mon();
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (oc_q.size() != 0) begin n_err++; $display("FAIL t6_dropped: got %0d outs want 0", oc_q.size()); end
    vec_q.delete();
    for (int p = 0; p < 4; p++) vec_q.push_back(ramp(16'(16'h0200 + p * 16), 16'd1));
    run_tile(4, 1, 1'b0, -1, -1, ok);
    n_cmp++;
    if (oc_q.size() != 4 || !ok) begin n_err++; $display("FAIL t6_rerun_count: got %0d want 4", oc_q.size()); end
    for (int i = 0; i < oc_q.size() && i < 4; i++) begin
      exp_v = ramp(16'(16'h0200 + i * 16), 16'd1);
      n_cmp++;
      if (od_q[i] !== exp_v) begin n_err++; $display("FAIL t6_rerun_data[%0d]: got %h want %h", i, od_q[i], exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_multi_group();
    test_wrap();
    test_bubbles();
    test_max_depth();
    test_cfg_err();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
